// File: rtl/axis_rr_arbiter.sv
// -----------------------------------------------------------------------------
// axis_rr_arbiter
//
// Packet-level round-robin arbiter. It shares one AXI4-Stream slave between
// N_SRC stream masters. One source is granted at a time, and the grant is held
// until that source's tlast beat is accepted downstream, so packets never
// interleave.
//
// Timing:
//   - Arbitration takes one cycle in IDLE.
//   - Beats pass through LOCK combinationally, with zero added latency.
//   - After every packet the arbiter spends one IDLE cycle before the next
//     grant.
//
// Optional feature (macro ARB_PKT_CNT_EN):
//   - defined   : adds pkt_cnt (completed-packet count, 16-bit wrapping) and
//                 src_pkt_cnt (per-source 8-bit wrapping counts, source i at
//                 [i*8 +: 8]).
//   - undefined : no counters and no extra ports.
//
// Ports:
//   clk          clock, all state on rising edge
//   rst          asynchronous active-low reset
//   s_valid      per-source tvalid               [N_SRC]
//   s_data       per-source tdata, i at [i*DW +: DW]
//   s_last       per-source tlast                [N_SRC]
//   s_ready      per-source tready               [N_SRC]
//   m_valid      tvalid to shared slave
//   m_data       tdata to shared slave           [DW]
//   m_last       tlast to shared slave
//   m_ready      tready from shared slave
//   grant_idx    currently (or last) granted source
//   busy         high while a packet is locked
//   pkt_cnt      (ARB_PKT_CNT_EN) completed packets
//   src_pkt_cnt  (ARB_PKT_CNT_EN) per-source completed packets
// -----------------------------------------------------------------------------
module axis_rr_arbiter #(
    parameter int N_SRC = 4,
    parameter int DW    = 8,
    parameter int IW    = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_SRC-1:0]    s_valid,
    input  logic [N_SRC*DW-1:0] s_data,
    input  logic [N_SRC-1:0]    s_last,
    output logic [N_SRC-1:0]    s_ready,
    output logic                m_valid,
    output logic [DW-1:0]       m_data,
    output logic                m_last,
    input  logic                m_ready,
    output logic [IW-1:0]       grant_idx,
    output logic                busy
`ifdef ARB_PKT_CNT_EN
    ,
    output logic [15:0]         pkt_cnt,
    output logic [N_SRC*8-1:0]  src_pkt_cnt
`endif
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    state_t          state_r;
    logic [IW-1:0]   rr_ptr_r;
    logic [IW-1:0]   grant_r;
    logic            busy_r;

    logic            handshake_s;
    logic            pkt_done_s;
    logic            any_req_s;
    logic [IW-1:0]   pick_s;

    // Successor index modulo N_SRC (N_SRC need not be a power of two).
    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] idx);
        logic [IW-1:0] nxt;
        if (idx == IW'(N_SRC - 1)) begin
            nxt = {IW{1'b0}};
        end else begin
            nxt = idx + IW'(1);
        end
        return nxt;
    endfunction

    // First requester found when scanning ptr, ptr+1, ... (mod N_SRC).
    function automatic logic [IW-1:0] rr_pick(input logic [N_SRC-1:0] req,
                                              input logic [IW-1:0]    ptr);
        logic [IW-1:0] cand;
        logic [IW-1:0] sel;
        logic          found;
        cand  = ptr;
        sel   = ptr;
        found = 1'b0;
        for (int k = 0; k < N_SRC; k++) begin
            if (!found && req[cand]) begin
                sel   = cand;
                found = 1'b1;
            end else begin
                sel   = sel;
            end
            cand = next_idx(cand);
        end
        return sel;
    endfunction

    // Request summary and round-robin candidate for the arbitration cycle.
    always_comb begin
        any_req_s = |s_valid;
        pick_s    = rr_pick(s_valid, rr_ptr_r);
    end

    // Stream mux: only the locked source is connected to the slave; all else idle.
    always_comb begin
        m_valid = 1'b0;
        m_data  = {DW{1'b0}};
        m_last  = 1'b0;
        s_ready = {N_SRC{1'b0}};
        for (int i = 0; i < N_SRC; i++) begin
            if (busy_r && (grant_r == IW'(i))) begin
                m_valid    = s_valid[i];
                m_data     = s_data[i*DW +: DW];
                m_last     = s_last[i];
                s_ready[i] = m_ready;
            end else begin
                s_ready[i] = 1'b0;
            end
        end
    end

    // Beat and end-of-packet detection on the shared slave side.
    always_comb begin
        handshake_s = m_valid & m_ready;
        pkt_done_s  = handshake_s & m_last;
    end

    // Arbitration FSM: grant in IDLE, hold until the tlast handshake, then advance pointer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r  <= ST_IDLE;
            rr_ptr_r <= {IW{1'b0}};
            grant_r  <= {IW{1'b0}};
            busy_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (any_req_s) begin
                        grant_r <= pick_s;
                        busy_r  <= 1'b1;
                        state_r <= ST_LOCK;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_LOCK: begin
                    if (pkt_done_s) begin
                        // Pointer moves past the winner even if it is the only requester.
                        rr_ptr_r <= next_idx(grant_r);
                        busy_r   <= 1'b0;
                        state_r  <= ST_IDLE;
                    end else begin
                        busy_r   <= 1'b1;
                        state_r  <= ST_LOCK;
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign grant_idx = grant_r;
    assign busy      = busy_r;

`ifdef ARB_PKT_CNT_EN
    logic [15:0]        pkt_cnt_r;
    logic [N_SRC*8-1:0] src_pkt_cnt_r;

    // Completed-packet counters; all wrap naturally at their width.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pkt_cnt_r     <= 16'd0;
            src_pkt_cnt_r <= {(N_SRC*8){1'b0}};
        end else begin
            if (pkt_done_s) begin
                pkt_cnt_r <= pkt_cnt_r + 16'd1;
            end else begin
                pkt_cnt_r <= pkt_cnt_r;
            end
            for (int i = 0; i < N_SRC; i++) begin
                if (pkt_done_s && (grant_r == IW'(i))) begin
                    src_pkt_cnt_r[i*8 +: 8] <= src_pkt_cnt_r[i*8 +: 8] + 8'd1;
                end else begin
                    src_pkt_cnt_r[i*8 +: 8] <= src_pkt_cnt_r[i*8 +: 8];
                end
            end
        end
    end

    assign pkt_cnt     = pkt_cnt_r;
    assign src_pkt_cnt = src_pkt_cnt_r;
`endif

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_axis_rr_arbiter
//
// Self-checking bench for axis_rr_arbiter (N_SRC=4, DW=8).
//
// Each source emits packets with randomised data. Packet length, gap between
// beats and valid probability are controlled per step.
//
// A reference model predicts every output of the arbiter each cycle. The model
// tracks three things:
//   - locked flag
//   - granted source
//   - round-robin pointer
//
// It applies the packet-level round-robin rules directly, using modular
// arithmetic.
// -----------------------------------------------------------------------------
module tb_axis_rr_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int IW = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      s_valid;
    logic [N*DW-1:0]   s_data;
    logic [N-1:0]      s_last;
    logic [N-1:0]      s_ready;
    logic              m_valid;
    logic [DW-1:0]     m_data;
    logic              m_last;
    logic              m_ready;
    logic [IW-1:0]     grant_idx;
    logic              busy;
`ifdef ARB_PKT_CNT_EN
    logic [15:0]       pkt_cnt;
    logic [N*8-1:0]    src_pkt_cnt;
`endif

    always #5 clk = ~clk;

    axis_rr_arbiter #(.N_SRC(N), .DW(DW), .IW(IW)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
        .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
        .grant_idx(grant_idx), .busy(busy)
`ifdef ARB_PKT_CNT_EN
        , .pkt_cnt(pkt_cnt), .src_pkt_cnt(src_pkt_cnt)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;

    // source generators
    bit            v[N];
    bit            l[N];
    logic [DW-1:0] d[N];
    int            beat[N];
    int            cur_len[N];
    int            len_cfg[N];
    int            gap[N];
    int            hold[N];
    logic [N-1:0]  en;
    int            p_valid;
    int            rdy_mode;
    bit            rdy_tog;

    // reference model
    bit            mdl_lock;
    int            mdl_g;
    int            mdl_ptr;
    int            mdl_pkts;

    // observation helpers
    int            dut_grants[$];
    bit            busy_prev;
    int            hs_obs;
    int            stall_obs;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic reset_bench();
        for (int i = 0; i < N; i++) begin
            v[i] = 1'b0; l[i] = 1'b0; d[i] = '0; beat[i] = 0; hold[i] = 0;
        end
        mdl_lock = 1'b0; mdl_g = 0; mdl_ptr = 0; mdl_pkts = 0;
        busy_prev = 1'b0;
        dut_grants.delete();
        hs_obs = 0; stall_obs = 0;
        rdy_tog = 1'b1;
    endtask

    // Reset with every source requesting; the arbiter must stay silent.
    task automatic do_reset();
        rst     = 1'b0;
        s_valid = '1;
        s_last  = '1;
        s_data  = '1;
        m_ready = 1'b1;
        @(posedge clk);
        #3;
        chk("rst_m_valid", m_valid, 0);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_grant", grant_idx, 0);
`ifdef ARB_PKT_CNT_EN
        chk("rst_pkt_cnt", pkt_cnt, 0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b1;
        reset_bench();
    endtask

    // One clock: drive sources, check outputs against the model, advance the model.
    task automatic cycle();
        logic [N-1:0] exp_rdy;
        logic         exp_mv;
        logic         exp_ml;
        logic [DW-1:0] exp_md;
        bit           hs;
        for (int i = 0; i < N; i++) begin
            if (!v[i] && en[i] && hold[i] == 0 && $urandom_range(0, 99) < p_valid) begin
                if (beat[i] == 0) cur_len[i] = (len_cfg[i] != 0) ? len_cfg[i] : $urandom_range(1, 4);
                v[i] = 1'b1;
                d[i] = DW'($urandom);
                l[i] = (beat[i] == cur_len[i] - 1);
            end
            s_valid[i]         = v[i];
            s_last[i]          = l[i];
            s_data[i*DW +: DW] = d[i];
        end
        case (rdy_mode)
            0:       m_ready = 1'b1;
            1:       m_ready = rdy_tog;
            default: m_ready = 1'($urandom_range(0, 1));
        endcase
        #3;
        exp_rdy = '0;
        exp_mv  = 1'b0;
        exp_ml  = 1'b0;
        exp_md  = '0;
        if (mdl_lock) begin
            exp_mv         = s_valid[mdl_g];
            exp_ml         = s_last[mdl_g];
            exp_md         = s_data[mdl_g*DW +: DW];
            exp_rdy[mdl_g] = m_ready;
        end
        chk("m_valid", m_valid, exp_mv);
        chk("m_data", m_data, exp_md);
        chk("m_last", m_last, exp_ml);
        chk("s_ready", s_ready, exp_rdy);
        chk("busy", busy, mdl_lock);
        chk("grant_idx", grant_idx, mdl_g);
`ifdef ARB_PKT_CNT_EN
        chk("pkt_cnt", pkt_cnt, mdl_pkts % 65536);
`endif
        if (busy === 1'b1 && !busy_prev) dut_grants.push_back(int'(grant_idx));
        busy_prev = (busy === 1'b1);
        if (m_valid === 1'b1 && m_ready) hs_obs++;
        if (busy === 1'b1 && m_valid === 1'b0) stall_obs++;
        @(posedge clk);
        hs = mdl_lock && s_valid[mdl_g] && m_ready;
        for (int i = 0; i < N; i++) begin
            if (hold[i] > 0) hold[i]--;
            if (hs && i == mdl_g) begin
                v[i] = 1'b0;
                if (l[i]) begin
                    beat[i] = 0;
                end else begin
                    beat[i]++;
                    hold[i] = gap[i];
                end
            end
        end
        if (!mdl_lock) begin
            for (int k = N - 1; k >= 0; k--) begin
                if (s_valid[(mdl_ptr + k) % N]) begin
                    mdl_g    = (mdl_ptr + k) % N;
                    mdl_lock = 1'b1;
                end
            end
        end else if (hs && s_last[mdl_g]) begin
            mdl_lock = 1'b0;
            mdl_ptr  = (mdl_g + 1) % N;
            mdl_pkts++;
        end
        rdy_tog = !rdy_tog;
        #1;
    endtask

    task automatic run_until(input int target, input int budget);
        for (int k = 0; k < budget && mdl_pkts < target; k++) cycle();
        chk("pkt_budget", (mdl_pkts >= target) ? 32'd1 : 32'd0, 1);
    endtask

    task automatic chk_grants(input string tag, input int exp_q[$]);
        chk({tag, "_cnt"}, (dut_grants.size() >= exp_q.size()) ? 32'd1 : 32'd0, 1);
        for (int k = 0; k < exp_q.size(); k++) begin
            if (k < dut_grants.size()) chk(tag, dut_grants[k], exp_q[k]);
        end
    endtask

    initial begin
        en = '0; p_valid = 100; rdy_mode = 0;
        for (int i = 0; i < N; i++) begin len_cfg[i] = 0; gap[i] = 0; cur_len[i] = 1; end
        reset_bench();
        #1;

        // Reset state with all sources requesting
        do_reset();

        // Fairness: four continuous requesters, 2-beat packets
        for (int i = 0; i < N; i++) len_cfg[i] = 2;
        en = 4'b1111;
        run_until(8, 200);
        chk_grants("fair_grant", '{0, 1, 2, 3, 0, 1, 2, 3});

        // Wrap/skip: move pointer to 2 via source 1, then sources 3 and 1 compete
        do_reset();
        en = 4'b0010;
        run_until(1, 50);
        en = 4'b1010;
        run_until(4, 200);
        chk_grants("wrap_grant", '{1, 3, 1, 3});

        // Backpressure: 4-beat packet from source 0, m_ready toggling
        do_reset();
        len_cfg[0] = 4; en = 4'b0001; rdy_mode = 1; rdy_tog = 1'b1;
        run_until(1, 50);
        chk("bp_beats", hs_obs, 4);
        rdy_mode = 0;

        // Bubble: source 2 pauses 3 cycles between beats while source 1 waits
        do_reset();
        len_cfg[2] = 3; len_cfg[1] = 2; gap[2] = 3;
        en = 4'b0100;
        cycle();
        en = 4'b0110;
        run_until(2, 100);
        chk("bubble_stall", stall_obs, 6);
        chk_grants("bubble_grant", '{2, 1});
        gap[2] = 0;

        // Randomised traffic, lengths, gaps and backpressure
        do_reset();
        for (int i = 0; i < N; i++) begin len_cfg[i] = 0; gap[i] = $urandom_range(0, 2); end
        en = 4'b1111; p_valid = 60; rdy_mode = 2;
        for (int k = 0; k < 1500; k++) cycle();
        chk("rand_progress", (mdl_pkts > 20) ? 32'd1 : 32'd0, 1);

        // Reset in the middle of a packet
        do_reset();
        len_cfg[0] = 4; en = 4'b0001; p_valid = 100; rdy_mode = 0;
        cycle(); cycle(); cycle();
        rst = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_m_valid", m_valid, 0);
        chk("midrst_s_ready", s_ready, 0);
`ifdef ARB_PKT_CNT_EN
        chk("midrst_pkt_cnt", pkt_cnt, 0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b1;
        reset_bench();
        run_until(1, 50);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
